stopwatch_bcd_timer: RTL and testbench

Cascaded BCD time counter generating the eight stopwatch digits, HH:MM:SS.hh, directly. It avoids the wide binary count and the divide/modulo chain. It sits between the start/pause latch and clear debouncer upstream and the per-digit `seg_display` instances downstream. Each nibble of `digitsOut` feeds one `segDigitsR` slot.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_bcd_timer_digit.sv | 40 ++++
 rtl/stopwatch_bcd_timer.sv | 119 +++++++++++
 tb/tb_stopwatch_bcd_timer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the BCD stopwatch: digit moduli (LSD first), digit sizing, tick dividers.
// Optional lap/hold feature is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;

  localparam int DIG_MOD_0 = 10;
  localparam int DIG_MOD_1 = 10;
  localparam int DIG_MOD_2 = 10;
  localparam int DIG_MOD_3 = 6;
  localparam int DIG_MOD_4 = 10;
  localparam int DIG_MOD_5 = 6;
  localparam int DIG_MOD_6 = 10;
  localparam int DIG_MOD_7 = 10;

  // 100 MHz clock down to 100 Hz, plus a short divider for simulation.
  localparam int TICK_DIV_SYNTH = 1_000_000;
  localparam int TICK_DIV_SIM   = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/stopwatch_bcd_timer_digit.sv
// One modulo-MOD BCD digit of the stopwatch chain; carry-out is combinational so carries ripple in one cycle.
// Used identically whether or not STOPWATCH_LAP_EN is defined.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic   clkIn,
  input  logic   rstW,
  input  logic   clrIn,
  input  logic   carryIn,
  output digit_t digitOut,
  output logic   carryOut
);

  localparam digit_t DIGIT_MAX = DIGIT_W'(MOD - 1);

  digit_t digit_q, digit_d;

  assign carryOut = carryIn & (digit_q == DIGIT_MAX);
  assign digitOut = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clrIn) begin
      digit_d = '0;
    end else if (carryIn) begin
      digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clkIn or posedge rstW) begin
    if (rstW) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_timer.sv
// Cascaded BCD stopwatch HH:MM:SS.hh: prescaler drives a ripple chain of eight bcd_digit counters.
// Define STOPWATCH_LAP_EN to add the lapIn port and a hold/snapshot display.
module stopwatch_bcd_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_SYNTH,
  parameter int PRE_W    = 20
) (
  input  logic                          clkIn,
  input  logic                          rstW,
  input  logic                          enIn,
  input  logic                          clearIn,
`ifdef STOPWATCH_LAP_EN
  input  logic                          lapIn,
`endif
  output logic [NUM_DIGITS*DIGIT_W-1:0] digitsOut,
  output logic                          tickOut,
  output logic                          wrapOut
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]              pre_q, pre_d;
  logic                          tick;
  logic                          tick_q, wrap_q;
  logic [NUM_DIGITS:0]           carry;
  logic [NUM_DIGITS*DIGIT_W-1:0] liveDigits;

  // A paused prescaler keeps its partial hundredth, including a pending terminal count.
  assign tick = enIn & (pre_q == PRE_MAX);

  always_comb begin
    pre_d = pre_q;
    if (clearIn || tick) begin
      pre_d = '0;
    end else if (enIn) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clkIn or posedge rstW) begin
    if (rstW) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick & ~clearIn;
      wrap_q <= carry[NUM_DIGITS] & ~clearIn;
    end
  end

  assign carry[0] = tick;

  bcd_digit #(.MOD(DIG_MOD_0)) uDig0 (.clkIn, .rstW, .clrIn(clearIn), .carryIn(carry[0]),
    .digitOut(liveDigits[3:0]),   .carryOut(carry[1]));
  bcd_digit #(.MOD(DIG_MOD_1)) uDig1 (.clkIn, .rstW, .clrIn(clearIn), .carryIn(carry[1]),
    .digitOut(liveDigits[7:4]),   .carryOut(carry[2]));
  bcd_digit #(.MOD(DIG_MOD_2)) uDig2 (.clkIn, .rstW, .clrIn(clearIn), .carryIn(carry[2]),
    .digitOut(liveDigits[11:8]),  .carryOut(carry[3]));
  bcd_digit #(.MOD(DIG_MOD_3)) uDig3 (.clkIn, .rstW, .clrIn(clearIn), .carryIn(carry[3]),
    .digitOut(liveDigits[15:12]), .carryOut(carry[4]));
  bcd_digit #(.MOD(DIG_MOD_4)) uDig4 (.clkIn, .rstW, .clrIn(clearIn), .carryIn(carry[4]),
    .digitOut(liveDigits[19:16]), .carryOut(carry[5]));
  bcd_digit #(.MOD(DIG_MOD_5)) uDig5 (.clkIn, .rstW, .clrIn(clearIn), .carryIn(carry[5]),
    .digitOut(liveDigits[23:20]), .carryOut(carry[6]));
  bcd_digit #(.MOD(DIG_MOD_6)) uDig6 (.clkIn, .rstW, .clrIn(clearIn), .carryIn(carry[6]),
    .digitOut(liveDigits[27:24]), .carryOut(carry[7]));
  bcd_digit #(.MOD(DIG_MOD_7)) uDig7 (.clkIn, .rstW, .clrIn(clearIn), .carryIn(carry[7]),
    .digitOut(liveDigits[31:28]), .carryOut(carry[8]));

  assign tickOut = tick_q;
  assign wrapOut = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic                          hold_q, hold_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] snap_q, snap_d, liveNext;

  // The snapshot must see this cycle's increment, so rebuild the digits' next values from the carries.
  always_comb begin
    liveNext = liveDigits;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry[i]) begin
        liveNext[i*DIGIT_W +: DIGIT_W] = carry[i+1] ? '0
                                       : liveDigits[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
      end
    end
  end

  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (clearIn) begin
      hold_d = 1'b0;
      snap_d = '0;
    end else if (lapIn) begin
      hold_d = ~hold_q;
      if (!hold_q) begin
        snap_d = liveNext;
      end
    end
  end

  always_ff @(posedge clkIn or posedge rstW) begin
    if (rstW) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign digitsOut = hold_q ? snap_q : liveDigits;
`else
  assign digitsOut = liveDigits;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_timer.sv
// Self-checking bench for stopwatch_bcd_timer against a hundredths-count model; lap checks when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_bcd_timer;

  localparam int          TD     = 4;
  localparam int unsigned MAXCNT = 36_000_000;

  logic        clkIn = 1'b0;
  logic        rstW = 1'b1;
  logic        enIn = 1'b0;
  logic        clearIn = 1'b0;
  logic        lapIn = 1'b0;
  logic [31:0] digitsOut;
  logic        tickOut;
  logic        wrapOut;
  logic [31:0] preVal;

  int          checks = 0;
  int          passes = 0;
  int          fails = 0;
  int          tickSeen;

  int unsigned mCnt, mSnap;
  int          mPre;
  logic        mTick, mWrap, mHold;

  always #5 clkIn = ~clkIn;

  stopwatch_bcd_timer #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .clkIn(clkIn),
    .rstW(rstW),
    .enIn(enIn),
    .clearIn(clearIn),
`ifdef STOPWATCH_LAP_EN
    .lapIn(lapIn),
`endif
    .digitsOut(digitsOut),
    .tickOut(tickOut),
    .wrapOut(wrapOut)
  );

  // Elapsed hundredths to HH:MM:SS.hh digits by plain arithmetic.
  function automatic logic [31:0] toBcd(input int unsigned c);
    int unsigned hh = c / 360000;
    int unsigned mm = (c / 6000) % 60;
    int unsigned ss = (c / 100) % 60;
    int unsigned hs = c % 100;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10), 4'(hs / 10), 4'(hs % 10)};
  endfunction

  function automatic logic [31:0] expDigits();
    return mHold ? toBcd(mSnap) : toBcd(mCnt);
  endfunction

  task automatic modelReset();
    mCnt = 0; mSnap = 0; mPre = 0; mTick = 0; mWrap = 0; mHold = 0;
  endtask

  task automatic modelStep();
    mTick = 0;
    mWrap = 0;
    if (clearIn) begin
      mPre = 0; mCnt = 0; mHold = 0; mSnap = 0;
    end else begin
      if (enIn) begin
        if (mPre == TD - 1) begin
          mPre = 0;
          mTick = 1;
          mCnt = mCnt + 1;
          if (mCnt == MAXCNT) begin
            mCnt = 0;
            mWrap = 1;
          end
        end else begin
          mPre = mPre + 1;
        end
      end
`ifdef STOPWATCH_LAP_EN
      if (lapIn) begin
        mHold = !mHold;
        if (mHold) mSnap = mCnt;
      end
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clkIn);
    modelStep();
    #1;
    if (tickOut === 1'b1) tickSeen++;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".digits"}, digitsOut, expDigits());
    checkVal({tag, ".tick"}, {31'd0, tickOut}, {31'd0, mTick});
    checkVal({tag, ".wrap"}, {31'd0, wrapOut}, {31'd0, mWrap});
  endtask

  task automatic applyStimulus(input logic en, input logic clr, input int n);
    enIn = en;
    clearIn = clr;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Loads a legal count directly into the digit registers while paused.
  task automatic preload(input int unsigned c);
    preVal = toBcd(c);
    enIn = 1'b0;
    clearIn = 1'b0;
    force dut.uDig0.digit_q = preVal[3:0];
    force dut.uDig1.digit_q = preVal[7:4];
    force dut.uDig2.digit_q = preVal[11:8];
    force dut.uDig3.digit_q = preVal[15:12];
    force dut.uDig4.digit_q = preVal[19:16];
    force dut.uDig5.digit_q = preVal[23:20];
    force dut.uDig6.digit_q = preVal[27:24];
    force dut.uDig7.digit_q = preVal[31:28];
    cycle();
    release dut.uDig0.digit_q;
    release dut.uDig1.digit_q;
    release dut.uDig2.digit_q;
    release dut.uDig3.digit_q;
    release dut.uDig4.digit_q;
    release dut.uDig5.digit_q;
    release dut.uDig6.digit_q;
    release dut.uDig7.digit_q;
    mCnt = c;
  endtask

  // Runs enabled until the model expects a tick; a missing DUT tick shows up as a failed check.
  task automatic runUntilTick();
    enIn = 1'b1;
    clearIn = 1'b0;
    for (int i = 0; i < TD + 1; i++) begin
      cycle();
      if (mTick) break;
    end
  endtask

  initial begin
    modelReset();
    #2;
    checkVal("reset.digits", digitsOut, 32'h0);
    checkVal("reset.tick", {31'd0, tickOut}, 32'h0);
    checkVal("reset.wrap", {31'd0, wrapOut}, 32'h0);
    #5 rstW = 1'b0;

    tickSeen = 0;
    applyStimulus(1'b1, 1'b0, 400);
    checkVal("run400.digits", digitsOut, 32'h0000_0100);
    checkVal("run400.ticks", 32'(tickSeen), 32'd100);
    checkOutput("run400");

    applyStimulus(1'b1, 1'b0, 2);
    tickSeen = 0;
    applyStimulus(1'b0, 1'b0, 50);
    checkVal("pause.digits", digitsOut, 32'h0000_0100);
    checkVal("pause.ticks", 32'(tickSeen), 32'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkVal("resume1.tick", {31'd0, tickOut}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1);
    checkVal("resume2.tick", {31'd0, tickOut}, 32'h1);
    checkVal("resume2.digits", digitsOut, 32'h0000_0101);

    preload(5999);
    checkVal("preload.digits", digitsOut, 32'h0000_5999);
    runUntilTick();
    checkVal("carry.digits", digitsOut, 32'h0001_0000);
    checkOutput("carry");

    preload(MAXCNT - 1);
    checkVal("prewrap.digits", digitsOut, 32'h9959_5999);
    runUntilTick();
    checkVal("wrap.digits", digitsOut, 32'h0);
    checkVal("wrap.pulse", {31'd0, wrapOut}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1);
    checkVal("wrap.oneCycle", {31'd0, wrapOut}, 32'h0);

    preload(1234);
    enIn = 1'b1;
    for (int i = 0; i < TD && mPre != TD - 1; i++) cycle();
    checkVal("clrTick.prePending", 32'(mPre), 32'(TD - 1));
    applyStimulus(1'b1, 1'b1, 1);
    checkVal("clrTick.digits", digitsOut, 32'h0);
    checkVal("clrTick.tick", {31'd0, tickOut}, 32'h0);
    checkOutput("clrTick");

    applyStimulus(1'b1, 1'b0, 37);
    #3 rstW = 1'b1;
    #1;
    modelReset();
    checkVal("asyncRst.digits", digitsOut, 32'h0);
    checkVal("asyncRst.tick", {31'd0, tickOut}, 32'h0);
    #1 rstW = 1'b0;

`ifdef STOPWATCH_LAP_EN
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 600);
    checkVal("lap.live150", digitsOut, 32'h0000_0150);
    lapIn = 1'b1;
    cycle();
    lapIn = 1'b0;
    checkVal("lap.enter", digitsOut, 32'h0000_0150);
    applyStimulus(1'b1, 1'b0, 400);
    checkVal("lap.held", digitsOut, 32'h0000_0150);
    checkOutput("lap.held");
    lapIn = 1'b1;
    cycle();
    lapIn = 1'b0;
    checkVal("lap.exit", digitsOut, 32'h0000_0250);
`endif

    for (int blk = 0; blk < 3; blk++) begin
      preload($urandom % MAXCNT);
      checkOutput("rand.preload");
      for (int i = 0; i < 500; i++) begin
        enIn = ($urandom % 8) != 0;
        clearIn = ($urandom % 64) == 0;
`ifdef STOPWATCH_LAP_EN
        lapIn = ($urandom % 40) == 0;
`endif
        cycle();
        checkOutput("rand");
      end
      lapIn = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
